// File: rtl/md_pkg.sv
// md_pkg: shared op and FSM state encodings for the iterative multiply/divide unit
package md_pkg;
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;
endpackage

// File: rtl/md_sign_adj.sv
// md_sign_adj: conditional two's-complement negation of a WIDTH-bit value
// Ports: in_val (value), neg (negate when 1), out_val (result)
module md_sign_adj #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_val,
  input  logic             neg,
  output logic [WIDTH-1:0] out_val
);
  assign out_val = neg ? ~in_val + WIDTH'(1) : in_val;
endmodule

// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative multiply/divide unit owning the HI/LO register pair
// Ports: Clk, Rst (async active-low); Start/Op/A/B request; HiWe/LoWe/WrData direct writes;
//        Busy (stall), Done (result pulse), Hi/Lo (registers). Option macro: MD_EARLY_OUT_EN.
module md_iter_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  md_state_e state_q, state_d;
  md_op_e op;
  logic [2*WIDTH-1:0] acc_q, acc_d, m_q, m_d, mul_step, div_step;
  logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_mag, b_mag, hi_neg, lo_neg, hi_res, lo_res;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, dz_q, dz_d, done_q, done_d;
  logic sgn, is_div, ge, last;
  logic [WIDTH:0] rem_sh, rem_new;
  assign op     = md_op_e'(Op);
  assign sgn    = (op == MD_MULT) || (op == MD_DIV);
  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  md_sign_adj #(.WIDTH(WIDTH)) u_sa_a  (.in_val(A), .neg(sgn & A[WIDTH-1]), .out_val(a_mag));
  md_sign_adj #(.WIDTH(WIDTH)) u_sa_b  (.in_val(B), .neg(sgn & B[WIDTH-1]), .out_val(b_mag));
  md_sign_adj #(.WIDTH(WIDTH)) u_sa_lo (.in_val(acc_q[WIDTH-1:0]), .neg(neg_lo_q), .out_val(lo_neg));
  md_sign_adj #(.WIDTH(WIDTH)) u_sa_hi (.in_val(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_hi_q), .out_val(hi_neg));
  assign mul_step = acc_q + (b_q[0] ? m_q : '0);
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge       = rem_sh >= {1'b0, b_q};
  assign rem_new  = ge ? rem_sh - {1'b0, b_q} : rem_sh;
  assign div_step = {rem_new[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
  // Negating a 2*WIDTH product: the high half only picks up the +1 carry when the low half is zero
  assign hi_res = (div_q || acc_q[WIDTH-1:0] == '0 || !neg_hi_q) ? hi_neg : ~acc_q[2*WIDTH-1:WIDTH];
  assign lo_res = dz_q ? '1 : lo_neg;
`ifdef MD_EARLY_OUT_EN
  assign last = (!div_q && b_q[WIDTH-1:1] == '0) || cnt_q == CNT_W'(1);
`else
  assign last = cnt_q == CNT_W'(1);
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    m_d      = m_q;
    b_d      = b_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        hi_d = HiWe ? WrData : hi_q;
        lo_d = LoWe ? WrData : lo_q;
        if (Start) begin
          state_d  = RUN;
          cnt_d    = CNT_W'(WIDTH);
          acc_d    = is_div ? {{WIDTH{1'b0}}, a_mag} : '0;
          m_d      = {{WIDTH{1'b0}}, a_mag};
          b_d      = b_mag;
          div_d    = is_div;
          neg_lo_d = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_hi_d = is_div ? sgn & A[WIDTH-1] : sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
          dz_d     = is_div && B == '0;
        end
      end
      RUN: begin
        acc_d   = div_q ? div_step : mul_step;
        m_d     = m_q << 1;
        b_d     = div_q ? b_q : b_q >> 1;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = last ? FIX : RUN;
      end
      FIX: begin
        hi_d    = hi_res;
        lo_d    = lo_res;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      m_q      <= '0;
      b_q      <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      b_q      <= b_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end
  assign Busy = state_q != IDLE;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;
endmodule

// File: tb/tb_md_iter_unit.sv
// tb_md_iter_unit: directed table-driven bench for md_iter_unit (WIDTH=32)
module tb_md_iter_unit;
  localparam int W = 32;
  logic Clk = 1'b0, Rst = 1'b0, Start = 1'b0, HiWe = 1'b0, LoWe = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [W-1:0] A = '0, B = '0, WrData = '0;
  logic Busy, Done;
  logic [W-1:0] Hi, Lo;
  int checks = 0, failures = 0;
  md_iter_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWe(HiWe), .LoWe(LoWe), .WrData(WrData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs[17];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
    logic [W-1:0] m;
    int e;
    m = (op == 2'b00 && b[W-1]) ? -b : b;
    e = 2;
    for (int k = 1; k < W; k++) if ((m >> k) != 0) e = k + 2;
`ifdef MD_EARLY_OUT_EN
    return op[1] ? W + 1 : e;
`else
    return (e > 0 && op != 2'b11) ? W + 1 : W + 1;
`endif
  endfunction
  task automatic wait_done(input int inject_at, output int busy_n, output int done_at, output logic [W-1:0] hi0);
    busy_n = 0;
    done_at = -1;
    hi0 = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (i == 0) begin
        Start = 1'b0;
        HiWe = 1'b0;
        LoWe = 1'b0;
        hi0 = Hi;
        chk("busy_first_cycle", {63'd0, Busy}, 64'd1);
        chk("done_low_first_cycle", {63'd0, Done}, 64'd0);
      end
      if (i == inject_at) begin
        Start = 1'b1; Op = 2'b01; A = 32'h0000_0009; B = 32'h0000_0009;
        HiWe = 1'b1; WrData = 32'hDEAD_BEEF;
      end
      if (i == inject_at + 1) begin
        Start = 1'b0;
        HiWe = 1'b0;
      end
      if (Done) begin
        done_at = i;
        break;
      end
      if (Busy) busy_n++;
    end
    if (done_at < 0) begin
      failures++;
      $display("FAIL done_timeout actual=none required=Done within 200 cycles");
    end
  endtask
  initial begin
    int busy_n, done_at, done_cnt;
    logic [W-1:0] hi0;
    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[6]  = '{2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006};
    vecs[7]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[8]  = '{2'b00, 32'h0000_0005, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC};
    vecs[9]  = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[10] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[11] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[12] = '{2'b00, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[13] = '{2'b00, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000};
    vecs[14] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[15] = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[16] = '{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};
    repeat (2) @(negedge Clk);
    chk("reset_hi", {32'd0, Hi}, 64'd0);
    chk("reset_lo", {32'd0, Lo}, 64'd0);
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_done", {63'd0, Done}, 64'd0);
    Rst = 1'b1;
    @(negedge Clk);
    LoWe = 1'b1; WrData = 32'h0000_1234;
    @(negedge Clk);
    LoWe = 1'b0;
    chk("lowe_lo", {32'd0, Lo}, 64'h1234);
    chk("lowe_hi_untouched", {32'd0, Hi}, 64'd0);
    chk("lowe_done", {63'd0, Done}, 64'd0);
    for (int v = 0; v < 17; v++) begin
      Start = 1'b1; Op = vecs[v].op; A = vecs[v].a; B = vecs[v].b;
      wait_done(-1, busy_n, done_at, hi0);
      chk($sformatf("v%0d_hi", v), {32'd0, Hi}, {32'd0, vecs[v].hi});
      chk($sformatf("v%0d_lo", v), {32'd0, Lo}, {32'd0, vecs[v].lo});
      chk($sformatf("v%0d_done_cycle", v), 64'(done_at), 64'(exp_lat(vecs[v].op, vecs[v].b)));
      chk($sformatf("v%0d_busy_cycles", v), 64'(busy_n), 64'(exp_lat(vecs[v].op, vecs[v].b)));
      chk($sformatf("v%0d_busy_in_done", v), {63'd0, Busy}, 64'd0);
    end
    @(negedge Clk);
    chk("done_single_pulse", {63'd0, Done}, 64'd0);
    chk("idle_after_table", {63'd0, Busy}, 64'd0);
    Start = 1'b1; Op = 2'b11; A = 32'h0000_0064; B = 32'h0000_0007;
    wait_done(9, busy_n, done_at, hi0);
    chk("ignored_start_hi", {32'd0, Hi}, 64'h2);
    chk("ignored_start_lo", {32'd0, Lo}, 64'hE);
    chk("ignored_start_done_cycle", 64'(done_at), 64'(W + 1));
    @(negedge Clk);
    chk("ignored_start_not_queued", {63'd0, Busy}, 64'd0);
    Start = 1'b1; Op = 2'b01; A = 32'h0000_0003; B = 32'h0000_0005;
    HiWe = 1'b1; WrData = 32'h0000_0055;
    wait_done(-1, busy_n, done_at, hi0);
    chk("start_hiwe_write_applied", {32'd0, hi0}, 64'h55);
    chk("start_hiwe_result_hi", {32'd0, Hi}, 64'd0);
    chk("start_hiwe_result_lo", {32'd0, Lo}, 64'hF);
    @(negedge Clk);
    HiWe = 1'b1; WrData = 32'h0000_ABCD;
    @(negedge Clk);
    HiWe = 1'b0;
    chk("hiwe_hi", {32'd0, Hi}, 64'hABCD);
    Start = 1'b1; Op = 2'b00; A = 32'h0000_1234; B = 32'h0000_5678;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("async_rst_busy", {63'd0, Busy}, 64'd0);
    chk("async_rst_hi", {32'd0, Hi}, 64'd0);
    chk("async_rst_lo", {32'd0, Lo}, 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done || Busy) done_cnt++;
    end
    chk("no_done_after_rst", 64'(done_cnt), 64'd0);
    chk("rst_hi_kept_zero", {32'd0, Hi}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
